// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer-width calculation and
// parameter legality check used at elaboration time.
package fifo_pkg;

  // Index width for a DEPTH-entry array, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // DEPTH must be a power of two >= 2; thresholds must be reachable occupancies.
  function automatic bit fifo_params_ok(input int depth, input int af_level,
                                        input int ae_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level <= depth) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// WIDTH x DEPTH storage: synchronous write port, asynchronous read port.
module fifo_dp_ram #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; occupancy is tracked by the pointers, so
  // stale contents are never observable and the array can map onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy count, registered status flags,
// overflow/underflow pulses and a show-ahead or registered read port.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = clog2_min1(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit SHOW_AHEAD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  if (!fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_error
    $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2, AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH");
  end

  localparam logic [ADDR_BITS:0] ONE       = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_CNT    = (ADDR_BITS + 1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_CNT    = (ADDR_BITS + 1)'(AE_LEVEL);

  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic [ADDR_BITS:0] count_nxt;
  logic [WIDTH-1:0]   ram_rdata;
  logic               wr_acc;
  logic               rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still takes a read
  // and an empty FIFO still takes a write in the same cycle.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_CNT);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

  fifo_dp_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[ADDR_BITS-1:0]),
    .rdata (ram_rdata)
  );

  if (SHOW_AHEAD) begin : g_show_ahead
    // Head word is visible as soon as the FIFO is non-empty; zero otherwise.
    assign rdata  = empty ? '0 : ram_rdata;
    assign rvalid = ~empty;
  end else begin : g_registered
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= ram_rdata;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one show-ahead and one registered-read instance
// share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int AE_LEVEL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] sa_rdata, rg_rdata;
  logic             sa_rvalid, rg_rvalid;
  logic             sa_full, rg_full, sa_empty, rg_empty;
  logic             sa_af, rg_af, sa_ae, rg_ae;
  logic [4:0]       sa_count, rg_count;
  logic             sa_ovf, rg_ovf, sa_unf, rg_unf;

  sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHOW_AHEAD(1'b1)) dut_sa (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(sa_rdata), .rvalid(sa_rvalid), .full(sa_full), .empty(sa_empty),
    .almost_full(sa_af), .almost_empty(sa_ae), .count(sa_count),
    .overflow(sa_ovf), .underflow(sa_unf)
  );

  sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHOW_AHEAD(1'b0)) dut_rg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rg_rdata), .rvalid(rg_rvalid), .full(rg_full), .empty(rg_empty),
    .almost_full(rg_af), .almost_empty(rg_ae), .count(rg_count),
    .overflow(rg_ovf), .underflow(rg_unf)
  );

  // Reference model: contents as a queue, plus the registered-port state.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf, m_unf, m_rg_valid;
  logic [WIDTH-1:0] m_rg_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rd);
    bit was_full, was_empty;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_rg_valid = 0; m_rg_data = '0;
      return;
    end
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_ovf = w && was_full;
    m_unf = rd && was_empty;
    m_rg_valid = rd && !was_empty;
    if (rd && !was_empty) m_rg_data = mq.pop_front();
    if (w && !was_full) mq.push_back(d);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic apply(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rd);
    rst = r; wr_en = w; wdata = d; rd_en = rd;
    @(posedge clk);
    model_step(r, w, d, rd);
    #1;
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [WIDTH-1:0] head;
    n = mq.size();
    head = (n != 0) ? mq[0] : '0;
    check({tag, " sa.count"},  sa_count,  n);
    check({tag, " rg.count"},  rg_count,  n);
    check({tag, " sa.empty"},  sa_empty,  n == 0);
    check({tag, " rg.empty"},  rg_empty,  n == 0);
    check({tag, " sa.full"},   sa_full,   n == DEPTH);
    check({tag, " rg.full"},   rg_full,   n == DEPTH);
    check({tag, " sa.af"},     sa_af,     n >= AF_LEVEL);
    check({tag, " rg.af"},     rg_af,     n >= AF_LEVEL);
    check({tag, " sa.ae"},     sa_ae,     n <= AE_LEVEL);
    check({tag, " rg.ae"},     rg_ae,     n <= AE_LEVEL);
    check({tag, " sa.ovf"},    sa_ovf,    m_ovf);
    check({tag, " rg.ovf"},    rg_ovf,    m_ovf);
    check({tag, " sa.unf"},    sa_unf,    m_unf);
    check({tag, " rg.unf"},    rg_unf,    m_unf);
    check({tag, " sa.rdata"},  sa_rdata,  head);
    check({tag, " sa.rvalid"}, sa_rvalid, n != 0);
    check({tag, " rg.rdata"},  rg_rdata,  m_rg_data);
    check({tag, " rg.rvalid"}, rg_rvalid, m_rg_valid);
  endtask

  typedef struct {
    bit               rst;
    bit               wr;
    logic [WIDTH-1:0] wd;
    bit               rd;
    int               cnt;
    bit               emp;
    bit               ful;
    bit               ae;
    bit               ovf;
    bit               unf;
    logic [WIDTH-1:0] sa_data;
    logic [WIDTH-1:0] rg_data;
    bit               rg_valid;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //           rst wr wd     rd cnt emp ful ae ovf unf sa     rg     rgv
    vecs[0] = '{1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 0};
    vecs[1] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 0};
    vecs[2] = '{0, 1, 8'h11, 0, 1, 0, 0, 1, 0, 0, 8'h11, 8'h00, 0};
    vecs[3] = '{0, 1, 8'h22, 0, 2, 0, 0, 1, 0, 0, 8'h11, 8'h00, 0};
    vecs[4] = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'h22, 8'h11, 1};
    vecs[5] = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 0, 8'h00, 8'h22, 1};
    vecs[6] = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'h00, 8'h22, 0};
    vecs[7] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h22, 0};
    vecs[8] = '{0, 1, 8'h33, 1, 1, 0, 0, 1, 0, 1, 8'h33, 8'h22, 0};
    vecs[9] = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 0, 8'h00, 8'h33, 1};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;

    // Table-driven vectors: reset, idle, basic push/pop, underflow, both-at-empty.
    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd);
      check({t, " count"},     sa_count,  vecs[i].cnt);
      check({t, " empty"},     sa_empty,  vecs[i].emp);
      check({t, " full"},      rg_full,   vecs[i].ful);
      check({t, " ae"},        rg_ae,     vecs[i].ae);
      check({t, " ovf"},       sa_ovf,    vecs[i].ovf);
      check({t, " unf"},       rg_unf,    vecs[i].unf);
      check({t, " sa.rdata"},  sa_rdata,  vecs[i].sa_data);
      check({t, " rg.rdata"},  rg_rdata,  vecs[i].rg_data);
      check({t, " rg.rvalid"}, rg_rvalid, vecs[i].rg_valid);
    end

    // Fill to full, then one rejected write.
    apply(1, 0, 8'h00, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      apply(0, 1, 8'(i), 0);
      check_all($sformatf("fill%0d", i));
      if (i == AF_LEVEL - 1) check("af below level", sa_af, 0);
      if (i == AF_LEVEL)     check("af at level", sa_af, 1);
    end
    check("full after 16", sa_full, 1);
    apply(0, 1, 8'hAA, 0);
    check("ovf on 17th", sa_ovf, 1);
    check("count stays 16", rg_count, 16);
    check_all("ovf cycle");
    apply(0, 0, 8'h00, 0);
    check("ovf one cycle", rg_ovf, 0);

    // Drain through the registered port; 0xAA must never appear.
    for (int i = 1; i <= DEPTH; i++) begin
      apply(0, 0, 8'h00, 1);
      check($sformatf("drain%0d rg.rdata", i), rg_rdata, i);
      check($sformatf("drain%0d rg.rvalid", i), rg_rvalid, 1);
      check_all($sformatf("drain%0d", i));
    end
    apply(0, 0, 8'h00, 1);
    check("unf after drain", rg_unf, 1);
    check("rvalid on unf", rg_rvalid, 0);
    check_all("unf cycle");

    // Wrap-around: pointers cross index 15 -> 0 on the second batch.
    apply(1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin apply(0, 1, 8'(8'h40 + i), 0); check_all("wrapA w"); end
    for (int i = 0; i < 10; i++) begin apply(0, 0, 8'h00, 1); check_all("wrapA r"); end
    for (int i = 0; i < 12; i++) begin apply(0, 1, 8'(8'h80 + i), 0); check_all("wrapB w"); end
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 8'h00, 1);
      check($sformatf("wrapB data%0d", i), rg_rdata, 8'h80 + i);
      check_all("wrapB r");
    end
    check("wrap count 0", sa_count, 0);

    // Simultaneous read and write at full, then at empty.
    for (int i = 0; i < DEPTH; i++) apply(0, 1, 8'(8'h20 + i), 0);
    apply(0, 1, 8'h77, 1);
    check("full both count", sa_count, DEPTH - 1);
    check("full both ovf", sa_ovf, 1);
    check("full both popped", rg_rdata, 8'h20);
    check_all("full both");
    for (int i = 0; i < DEPTH - 1; i++) apply(0, 0, 8'h00, 1);
    check("drained empty", sa_empty, 1);
    apply(0, 1, 8'h99, 1);
    check("empty both count", rg_count, 1);
    check("empty both unf", sa_unf, 1);
    check("empty both sa head", sa_rdata, 8'h99);
    check_all("empty both");
    apply(0, 0, 8'h00, 1);
    check("empty both rg data", rg_rdata, 8'h99);
    check("empty both rg valid", rg_rvalid, 1);

    // Reset in the middle of a write discards everything.
    for (int i = 0; i < 9; i++) apply(0, 1, 8'(8'h60 + i), 0);
    check("pre-reset count", sa_count, 9);
    apply(1, 1, 8'h44, 0);
    check("mid reset count", sa_count, 0);
    check("mid reset empty", rg_empty, 1);
    check_all("mid reset");
    apply(0, 1, 8'h5C, 0);
    check("post reset sa data", sa_rdata, 8'h5C);
    check("post reset sa valid", sa_rvalid, 1);
    check_all("post reset");

    // Randomised traffic in phases with different read/write biases.
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
      for (int c = 0; c < 600; c++) begin
        bit r, w, rd;
        r  = ($urandom_range(0, 299) == 0);
        w  = ($urandom_range(0, 99) < pw);
        rd = ($urandom_range(0, 99) < pr);
        apply(r, w, 8'($urandom_range(0, 255)), rd);
        check_all($sformatf("rand p%0d c%0d", ph, c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO that combines storage, read/write pointers, occupancy tracking and status flags in one block. It buffers words between a producer and a consumer in the same clock domain, such as register-file or ALU results queued toward the UART TX path. It adds full/empty, programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable read mode (show-ahead or registered).

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; must be a power of two and ≥ 2
ADDR_BITS, $clog2(DEPTH), pointer index width (derived; do not override)
AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
SHOW_AHEAD, 1, 1 = rdata shows the head word combinationally; 0 = rdata is registered one cycle after an accepted read

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset
wr_en  in  1  write request
wdata  in  WIDTH  write data
rd_en  in  1  read request
rdata  out  WIDTH  read data
rvalid  out  1  rdata valid strobe
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AF_LEVEL
almost_empty  out  1  count ≤ AE_LEVEL
count  out  ADDR_BITS+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- On a clock edge with rst=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, almost_empty=1; full=0, almost_full=0.
  - overflow=0, underflow=0, rvalid=0, registered rdata=0.
  - Storage array is NOT cleared.
- Reset mid-operation discards all contents; the next cycle behaves as freshly reset.
- Write accepted = wr_en & ~full (full is the current registered state). When accepted: mem[wr_ptr[ADDR_BITS-1:0]] <= wdata and wr_ptr increments.
- Read accepted = rd_en & ~empty. When accepted, rd_ptr increments.
- Pointers are ADDR_BITS+1 bits wide and wrap naturally at 2*DEPTH. The index is the low ADDR_BITS bits.
- Count update per cycle: +1 on write-only, −1 on read-only, unchanged when both or neither are accepted.
- Simultaneous wr_en & rd_en:
  - When full: read accepted, write rejected, overflow pulses; count becomes DEPTH-1.
  - When empty: write accepted, read rejected, underflow pulses; count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- overflow and underflow are registered and high for exactly the cycle after the rejected request. They are not sticky.
- All status flags are registered and derived from the next count value. They are accurate in the cycle after the causing edge, with no extra lag.
- SHOW_AHEAD=1:
  - rdata = mem[rd_ptr index] combinationally; rdata = 0 while empty.
  - rvalid = ~empty.
  - An accepted read pops the word that was visible in that cycle.
- SHOW_AHEAD=0:
  - On an accepted read, rdata <= mem[rd_ptr index] and rvalid <= 1 for one cycle; read latency is 1.
  - Otherwise rvalid <= 0 and rdata holds its value.
- A write to an empty FIFO becomes visible at the earliest:
  - SHOW_AHEAD=1: in the next cycle.
  - SHOW_AHEAD=0: a read issued in the next cycle returns it one cycle later.
- No bypass path: a word is never read in the same cycle it is written.

Decomposition:
- Package fifo_pkg holds:
  - function clog2_min1 (returns ≥ 1 for DEPTH=2 corner cases);
  - a localparam check helper: elaboration-time $error if DEPTH is not a power of two, or if AF_LEVEL > DEPTH or AE_LEVEL ≥ DEPTH.
- One sub-module, fifo_dp_ram: WIDTH×DEPTH, synchronous write on clk with write enable, asynchronous read, no reset on the array.
- The top level contains the pointers, count, flags and read-mode logic.

Test Plan:
1. Reset then idle (WIDTH=8, DEPTH=16) → empty=1, almost_empty=1, full=0, count=0, rvalid=0, rdata=0.
2. Write 0x01..0x10 (16 writes), then a 17th write 0xAA → full=1 and almost_full=1 at count≥14; overflow pulses once; count stays 16; 0xAA is never read back.
3. Drain with SHOW_AHEAD=0 → rdata sequence 0x01..0x10, each one cycle after its rd_en with rvalid=1. A read after empty → underflow pulse, rvalid=0.
4. Wrap-around: write 10, read 10, then write 12 and read 12 → the data order is preserved across the pointer wrap at index 15→0; count returns to 0.
5. At full, assert wr_en & rd_en together → read accepted, overflow=1, count=15. At empty, assert both → count=1, underflow=1, the written word is read next.
6. Assert rst with count=9 during a write → next cycle count=0, empty=1. With SHOW_AHEAD=1 a subsequent write of 0x5C shows rdata=0x5C with rvalid=1 one cycle later.
